// File: rtl/fp_sum_initiator.sv
// Serial FP32 reduction initiator: pulls N terms and drives an external adder
// through the a/b/z stb/ack handshake so that acc = acc + term, reporting the final sum.
module fp_sum_initiator #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COUNT_W-1:0] count,
   output logic               busy,
   input  logic [31:0]        term_data,
   input  logic               term_valid,
   output logic               term_ready,
   output logic [31:0]        a_out,
   output logic               a_stb,
   input  logic               a_ack,
   output logic [31:0]        b_out,
   output logic               b_stb,
   input  logic               b_ack,
   input  logic [31:0]        z_in,
   input  logic               z_stb,
   output logic               z_ack,
   output logic [31:0]        sum,
   output logic               done
);

   typedef enum logic [2:0] {IDLE, FETCH0, FETCH, SEND, WAIT_Z} state_t;

   state_t             state, state_nxt;
   logic [COUNT_W-1:0] n_reg, n_nxt;
   logic [COUNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic [31:0]        acc, acc_nxt;
   logic [31:0]        a_out_nxt, b_out_nxt, sum_nxt;
   logic               term_ready_nxt, a_stb_nxt, b_stb_nxt, z_ack_nxt, done_nxt;
   logic               term_xfer, z_xfer;

   assign busy      = (state != IDLE);
   assign cnt_inc   = cnt + 1'b1;
   assign term_xfer = term_valid && term_ready;
   assign z_xfer    = z_stb && z_ack;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         n_reg      <= '0;
         cnt        <= '0;
         acc        <= '0;
         term_ready <= 1'b0;
         a_stb      <= 1'b0;
         b_stb      <= 1'b0;
         z_ack      <= 1'b0;
         done       <= 1'b0;
         a_out      <= '0;
         b_out      <= '0;
         sum        <= '0;
      end else begin
         state      <= state_nxt;
         n_reg      <= n_nxt;
         cnt        <= cnt_nxt;
         acc        <= acc_nxt;
         term_ready <= term_ready_nxt;
         a_stb      <= a_stb_nxt;
         b_stb      <= b_stb_nxt;
         z_ack      <= z_ack_nxt;
         done       <= done_nxt;
         a_out      <= a_out_nxt;
         b_out      <= b_out_nxt;
         sum        <= sum_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      n_nxt          = n_reg;
      cnt_nxt        = cnt;
      acc_nxt        = acc;
      term_ready_nxt = term_ready;
      a_stb_nxt      = a_stb;
      b_stb_nxt      = b_stb;
      z_ack_nxt      = z_ack;
      done_nxt       = 1'b0;
      a_out_nxt      = a_out;
      b_out_nxt      = b_out;
      sum_nxt        = sum;
      case (state)
         IDLE: begin
            if (start) begin
               if (count == '0) begin
                  sum_nxt  = '0;
                  done_nxt = 1'b1;
               end else begin
                  n_nxt          = count;
                  cnt_nxt        = '0;
                  term_ready_nxt = 1'b1;
                  state_nxt      = FETCH0;
               end
            end
         end
         // First term seeds the accumulator directly; no adder pass needed.
         FETCH0: begin
            if (term_xfer) begin
               acc_nxt = term_data;
               cnt_nxt = COUNT_W'(1);
               if (n_reg == COUNT_W'(1)) begin
                  sum_nxt        = term_data;
                  done_nxt       = 1'b1;
                  term_ready_nxt = 1'b0;
                  state_nxt      = IDLE;
               end else begin
                  state_nxt = FETCH;
               end
            end
         end
         FETCH: begin
            if (term_xfer) begin
               a_out_nxt      = acc;
               b_out_nxt      = term_data;
               term_ready_nxt = 1'b0;
               a_stb_nxt      = 1'b1;
               b_stb_nxt      = 1'b1;
               state_nxt      = SEND;
            end
         end
         // Operand acks are independent; leave only once both have landed.
         SEND: begin
            if (a_stb && a_ack) a_stb_nxt = 1'b0;
            if (b_stb && b_ack) b_stb_nxt = 1'b0;
            if (!a_stb_nxt && !b_stb_nxt) begin
               z_ack_nxt = 1'b1;
               state_nxt = WAIT_Z;
            end
         end
         WAIT_Z: begin
            if (z_xfer) begin
               acc_nxt   = z_in;
               cnt_nxt   = cnt_inc;
               z_ack_nxt = 1'b0;
               if (cnt_inc == n_reg) begin
                  sum_nxt   = z_in;
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  term_ready_nxt = 1'b1;
                  state_nxt      = FETCH;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fp_sum_initiator.sv
// Directed bench for fp_sum_initiator: term feeder, behavioural adder with
// programmable ack/result delays, and a sum/latency scoreboard checked on done.
module tb_fp_sum_initiator;

   localparam int COUNT_W = 8;

   logic               clk, reset, start;
   logic [COUNT_W-1:0] count;
   logic               busy;
   logic [31:0]        term_data;
   logic               term_valid, term_ready;
   logic [31:0]        a_out, b_out, z_in, sum;
   logic               a_stb, a_ack, b_stb, b_ack, z_stb, z_ack, done;

   fp_sum_initiator #(.COUNT_W(COUNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .count(count), .busy(busy),
      .term_data(term_data), .term_valid(term_valid), .term_ready(term_ready),
      .a_out(a_out), .a_stb(a_stb), .a_ack(a_ack),
      .b_out(b_out), .b_stb(b_stb), .b_ack(b_ack),
      .z_in(z_in), .z_stb(z_stb), .z_ack(z_ack),
      .sum(sum), .done(done)
   );

   typedef struct {
      logic [31:0] sum;
      int          lat;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] term_q[$];
   int vectors = 0, errs = 0, cyc = 0, e0 = 0, ndone = 0;
   int a_dly = 0, b_dly = 0, z_dly = 0;
   int delivered = 0, stall_at = -1, stall_len = 0;
   bit tr_seen, as_seen, drop_err, stab_err, zack_early;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic int fp2int(input logic [31:0] f);
      int e, m;
      if (f[30:0] == 31'd0) return 0;
      e = int'(f[30:23]) - 127;
      m = {8'd0, 1'b1, f[22:0]};
      m = m >>> (23 - e);
      return f[31] ? -m : m;
   endfunction

   function automatic logic [31:0] int2fp(input int v);
      logic [31:0] m;
      logic        s;
      int          p;
      if (v == 0) return 32'd0;
      s = (v < 0);
      m = s ? -v : v;
      p = 0;
      for (int i = 0; i < 31; i++) if (m[i]) p = i;
      m = (m << (23 - p)) & 32'h007F_FFFF;
      return {s, 8'(127 + p), m[22:0]};
   endfunction

   // Term source: valid held until transfer; optional stall after a given term.
   initial begin
      bit tv_prev, tr_prev;
      int stall;
      term_valid = 0; term_data = 0; tv_prev = 0; tr_prev = 0; stall = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            term_q.delete();
            term_valid = 0; stall = 0; tv_prev = 0; tr_prev = 0;
         end else begin
            if (tv_prev && tr_prev) begin
               void'(term_q.pop_front());
               delivered++;
               if (delivered == stall_at) stall = stall_len;
            end
            if (stall > 0) begin
               stall--;
               term_valid = 0;
            end else begin
               term_valid = (term_q.size() > 0);
               if (term_valid) term_data = term_q[0];
            end
            tv_prev = term_valid;
            tr_prev = term_ready;
         end
      end
   end

   // Behavioural adder: integer-valued FP32 operands, independent ack delays.
   initial begin
      bit have_a, have_b, zk_prev;
      int acnt, bcnt, zcnt;
      logic [31:0] opa, opb;
      a_ack = 0; b_ack = 0; z_stb = 0; z_in = 0;
      have_a = 0; have_b = 0; zk_prev = 0; acnt = 0; bcnt = 0; zcnt = 0; opa = 0; opb = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            a_ack = 0; b_ack = 0; z_stb = 0;
            have_a = 0; have_b = 0; zk_prev = 0; acnt = 0; bcnt = 0; zcnt = 0;
         end else begin
            if (z_stb && zk_prev) begin
               z_stb = 0; have_a = 0; have_b = 0; zcnt = 0;
            end
            if (a_ack) begin
               a_ack = 0; have_a = 1; acnt = 0;
            end else if (a_stb && !have_a) begin
               if (acnt >= a_dly) begin a_ack = 1; opa = a_out; end
               else acnt++;
            end
            if (b_ack) begin
               b_ack = 0; have_b = 1; bcnt = 0;
            end else if (b_stb && !have_b) begin
               if (bcnt >= b_dly) begin b_ack = 1; opb = b_out; end
               else bcnt++;
            end
            if (have_a && have_b && !z_stb) begin
               if (zcnt >= z_dly) begin
                  z_stb = 1;
                  z_in  = int2fp(fp2int(opa) + fp2int(opb));
               end else zcnt++;
            end
            zk_prev = z_ack;
         end
      end
   end

   // Protocol monitor and scoreboard consumer, sampled mid low phase.
   initial begin
      bit pxa, pxb, pa, pb;
      logic [31:0] pa_out, pb_out;
      exp_t e;
      pxa = 0; pxb = 0; pa = 0; pb = 0; pa_out = 0; pb_out = 0;
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            if (term_ready) tr_seen = 1;
            if (a_stb) as_seen = 1;
            if ((pxa && a_stb) || (pxb && b_stb)) drop_err = 1;
            if ((a_stb && pa && a_out !== pa_out) || (b_stb && pb && b_out !== pb_out)) stab_err = 1;
            if (z_ack && (a_stb || b_stb)) zack_early = 1;
            if (done) begin
               ndone++;
               if (exp_q.size() == 0) check("spurious_done", 32'(done), 32'd0);
               else begin
                  e = exp_q.pop_front();
                  check("sum", sum, e.sum);
                  if (e.lat >= 0) check("done_latency", 32'(cyc - e0), 32'(e.lat));
               end
            end
         end
         pxa = a_stb && a_ack; pxb = b_stb && b_ack;
         pa = a_stb; pb = b_stb; pa_out = a_out; pb_out = b_out;
      end
   end

   task automatic go(input int n, input logic [31:0] s, input int lat);
      exp_t e;
      e.sum = s; e.lat = lat;
      tr_seen = 0; as_seen = 0; drop_err = 0; stab_err = 0; zack_early = 0; delivered = 0;
      exp_q.push_back(e);
      @(negedge clk);
      count = COUNT_W'(n); start = 1;
      @(posedge clk);
      #1 e0 = cyc;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int i = 0;
      while (ndone < target && i < budget) begin
         @(negedge clk);
         #3;
         i++;
      end
      check("done_count", 32'(ndone), 32'(target));
   endtask

   task automatic check_outputs_zero(input string pfx);
      check({pfx, "_busy"}, 32'(busy), 0);
      check({pfx, "_term_ready"}, 32'(term_ready), 0);
      check({pfx, "_a_stb"}, 32'(a_stb), 0);
      check({pfx, "_b_stb"}, 32'(b_stb), 0);
      check({pfx, "_z_ack"}, 32'(z_ack), 0);
      check({pfx, "_done"}, 32'(done), 0);
      check({pfx, "_a_out"}, a_out, 0);
      check({pfx, "_b_out"}, b_out, 0);
      check({pfx, "_sum"}, sum, 0);
   endtask

   task automatic check_protocol(input string pfx);
      check({pfx, "_stb_drop"}, 32'(drop_err), 0);
      check({pfx, "_data_stable"}, 32'(stab_err), 0);
      check({pfx, "_z_ack_early"}, 32'(zack_early), 0);
   endtask

   initial begin
      int i;
      reset = 1; start = 0; count = 0;
      repeat (2) @(posedge clk);
      #1 check_outputs_zero("reset");
      @(negedge clk) reset = 0;

      // 1+2+3 with a zero-wait adder
      term_q.push_back(32'h3F80_0000); term_q.push_back(32'h4000_0000); term_q.push_back(32'h4040_0000);
      go(3, 32'h40C0_0000, 7);
      check("busy_running", 32'(busy), 1);
      wait_done(1, 50);
      repeat (4) @(negedge clk);
      #3 check("single_done", 32'(ndone), 1);
      check("busy_after", 32'(busy), 0);

      // N=0: immediate zero sum, no term requested
      go(0, 32'h0000_0000, 0);
      wait_done(2, 20);
      check("n0_no_term_ready", 32'(tr_seen), 0);

      // N=1: lone term passes through, adder untouched
      term_q.push_back(32'hC120_0000);
      go(1, 32'hC120_0000, 1);
      wait_done(3, 20);
      check("n1_no_a_stb", 32'(as_seen), 0);

      // a_ack two cycles ahead of b_ack
      a_dly = 0; b_dly = 2;
      term_q.push_back(32'h3F80_0000); term_q.push_back(32'h4000_0000);
      go(2, 32'h4040_0000, -1);
      wait_done(4, 50);
      check_protocol("skew");

      // both acks late but coincident
      a_dly = 2; b_dly = 2;
      term_q.push_back(32'h4000_0000); term_q.push_back(32'h4040_0000);
      go(2, 32'h40A0_0000, -1);
      wait_done(5, 50);
      check_protocol("same");

      // slow result and a mid-stream term gap
      a_dly = 0; b_dly = 0; z_dly = 5; stall_at = 2; stall_len = 3;
      repeat (4) term_q.push_back(32'h3F80_0000);
      go(4, 32'h4080_0000, -1);
      wait_done(6, 100);
      check_protocol("stall");
      check("stall_terms_used", 32'(delivered), 4);
      stall_at = -1;

      // reset while waiting on the adder result
      z_dly = 30;
      term_q.push_back(32'h3F80_0000); term_q.push_back(32'h4000_0000); term_q.push_back(32'h4040_0000);
      go(3, 32'h40C0_0000, -1);
      i = 0;
      while (!z_ack && i < 50) begin @(negedge clk); #3; i++; end
      check("reach_wait_z", 32'(z_ack), 1);
      @(negedge clk) reset = 1;
      @(posedge clk);
      #1 check_outputs_zero("midrun_reset");
      exp_q.delete();
      @(negedge clk);
      @(negedge clk) reset = 0;
      z_dly = 0;
      term_q.push_back(32'h4000_0000); term_q.push_back(32'h4000_0000);
      go(2, 32'h4080_0000, 4);
      wait_done(7, 50);

      // start with another count while busy must be ignored
      term_q.push_back(32'h3F80_0000); term_q.push_back(32'h4000_0000); term_q.push_back(32'h4040_0000);
      go(3, 32'h40C0_0000, 7);
      count = 8'd5; start = 1;
      @(negedge clk) start = 0;
      wait_done(8, 50);
      repeat (10) @(negedge clk);
      #3 check("busy_start_single_done", 32'(ndone), 8);
      check("busy_start_idle", 32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
